// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: reading-side bus master for the CPU register file.
// Latches a move request, samples the selected source onto BUS and pulses
// a one-hot LD strobe so the register file captures it (IDLE -> SEL -> LOAD).
// Optional transfer counter: define BUS_TRANSFER_CTRL_XFER_CNT_EN to add xfer_cnt.
module bus_transfer_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_src,
    input  logic [1:0]       req_dst,
    input  logic [WIDTH-1:0] req_imm,
    input  logic [WIDTH-1:0] t0,
    input  logic [WIDTH-1:0] t1,
    input  logic [WIDTH-1:0] t2,
    input  logic [WIDTH-1:0] t3,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] src_const,
    output logic [WIDTH-1:0] BUS,
    output logic [3:0]       LD,
    output logic             busy,
    output logic             done
`ifdef BUS_TRANSFER_CTRL_XFER_CNT_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    localparam int unsigned SRC_W = 3;
    localparam int unsigned DST_W = 2;
    localparam int unsigned LD_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [DST_W-1:0]   dst_q, dst_d;
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic [WIDTH-1:0]   bus_q, bus_d;
    logic [LD_W-1:0]    ld_q, ld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   sel_c;

    // Source multiplexer driven by the latched source code.
    always_comb begin
        sel_c = WIDTH'(0);
        case (src_q)
            3'd0:    sel_c = t0;
            3'd1:    sel_c = t1;
            3'd2:    sel_c = t2;
            3'd3:    sel_c = t3;
            3'd4:    sel_c = i0;
            3'd5:    sel_c = i1;
            3'd6:    sel_c = src_const;
            default: sel_c = imm_q;
        endcase
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        bus_d   = bus_q;
        ld_d    = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    src_d   = req_src;
                    dst_d   = req_dst;
                    imm_d   = req_imm;
                    state_d = SEL;
                end
            end
            SEL: begin
                bus_d   = sel_c;
                state_d = LOAD;
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE: ready_d = 1'b1;
            SEL:  busy_d  = 1'b1;
            LOAD: begin
                busy_d = 1'b1;
                done_d = 1'b1;
                ld_d   = LD_W'(4'b1000 >> dst_d);
            end
            default: ready_d = 1'b1;
        endcase
    end

    // State and registered-output update; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            bus_q   <= '0;
            ld_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            imm_q   <= imm_d;
            bus_q   <= bus_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign BUS       = bus_q;
    assign LD        = ld_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_ready = ready_q;

`ifdef BUS_TRANSFER_CTRL_XFER_CNT_EN
    logic [15:0] cnt_q;

    // Count transfers that complete their LOAD cycle; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else if (state_q == LOAD) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed bench for bus_transfer_ctrl with a small register-file model
// that captures BUS into t0..t3 on the LD strobe.
module tb_bus_transfer_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_src = 3'd0;
    logic [1:0]       req_dst = 2'd0;
    logic [WIDTH-1:0] req_imm = '0;
    logic [WIDTH-1:0] t0 = '0;
    logic [WIDTH-1:0] t1 = '0;
    logic [WIDTH-1:0] t2 = '0;
    logic [WIDTH-1:0] t3 = '0;
    logic [WIDTH-1:0] i0 = '0;
    logic [WIDTH-1:0] i1 = '0;
    logic [WIDTH-1:0] src_const = '0;
    logic [WIDTH-1:0] BUS;
    logic [3:0]       LD;
    logic             busy;
    logic             done;
`ifdef BUS_TRANSFER_CTRL_XFER_CNT_EN
    logic [15:0]      xfer_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    bus_transfer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_imm   (req_imm),
        .t0        (t0),
        .t1        (t1),
        .t2        (t2),
        .t3        (t3),
        .i0        (i0),
        .i1        (i1),
        .src_const (src_const),
        .BUS       (BUS),
        .LD        (LD),
        .busy      (busy),
        .done      (done)
`ifdef BUS_TRANSFER_CTRL_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Register-file model: capture BUS into the strobed destination.
    always @(posedge clk) begin
        if (LD[3]) t0 <= BUS;
        if (LD[2]) t1 <= BUS;
        if (LD[1]) t2 <= BUS;
        if (LD[0]) t3 <= BUS;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_ld"},    32'(LD),        32'h0);
        chk({tag, "_done"},  32'(done),      32'h0);
        chk({tag, "_busy"},  32'(busy),      32'h0);
        chk({tag, "_ready"}, 32'(req_ready), 32'h1);
    endtask

    logic [15:0] t1_before;
    logic [3:0]  exp_ld;

    initial begin
        // 1: reset for two cycles
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_bus", 32'(BUS), 32'h0);
        idle_outs("rst");
`ifdef BUS_TRANSFER_CTRL_XFER_CNT_EN
        chk("rst_cnt", 32'(xfer_cnt), 32'h0);
`endif

        // 2: i0 -> t2
        i0 = 16'd10;
        req_src = 3'd4; req_dst = 2'd2; req_valid = 1'b1;
        tick();                                   // E0
        req_valid = 1'b0;
        chk("t2_sel_busy",  32'(busy),      32'h1);
        chk("t2_sel_ready", 32'(req_ready), 32'h0);
        chk("t2_sel_ld",    32'(LD),        32'h0);
        chk("t2_sel_done",  32'(done),      32'h0);
        tick();                                   // E1
        chk("t2_load_bus",  32'(BUS),  32'h000A);
        chk("t2_load_ld",   32'(LD),   32'b0010);
        chk("t2_load_done", 32'(done), 32'h1);
        chk("t2_load_busy", 32'(busy), 32'h1);
        tick();                                   // E2
        idle_outs("t2_after");
        chk("t2_after_bus", 32'(BUS), 32'h000A);
        chk("t2_value",     32'(t2),  32'h000A);

        // 3: immediate -> t0, then t0 -> t3 back-to-back (read-after-write)
        req_src = 3'd7; req_imm = 16'hBEEF; req_dst = 2'd0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; req_imm = 16'h0000;
        tick();
        chk("imm_ld",  32'(LD),  32'b1000);
        chk("imm_bus", 32'(BUS), 32'hBEEF);
        tick();
        chk("imm_t0",  32'(t0),  32'hBEEF);
        req_src = 3'd0; req_dst = 2'd3; req_valid = 1'b1;
        tick();                                   // E3
        req_valid = 1'b0;
        tick();                                   // E4
        chk("raw_ld",  32'(LD),  32'b0001);
        chk("raw_bus", 32'(BUS), 32'hBEEF);
        tick();
        chk("raw_t3",  32'(t3),  32'hBEEF);
        idle_outs("raw_after");

        // 4: req_valid held high with fields changing every cycle
        req_valid = 1'b1;
        req_src   = 3'd7;
        for (int j = 0; j < 9; j++) begin
            req_imm = 16'h1000 + 16'(j);
            req_dst = 2'(j);
            tick();
            if (j % 3 == 1) begin
                exp_ld = 4'b1000 >> (2'(j - 1));
                chk($sformatf("hold%0d_ld", j),  32'(LD),   32'(exp_ld));
                chk($sformatf("hold%0d_bus", j), 32'(BUS),  32'(16'h1000 + 16'(j - 1)));
                chk($sformatf("hold%0d_done", j), 32'(done), 32'h1);
            end else begin
                chk($sformatf("hold%0d_ld", j),   32'(LD),   32'h0);
                chk($sformatf("hold%0d_done", j), 32'(done), 32'h0);
            end
            chk($sformatf("hold%0d_ready", j), 32'(req_ready), (j % 3 == 2) ? 32'h1 : 32'h0);
        end
        req_valid = 1'b0;

        // 5: reset during SEL aborts the transfer
        i1 = 16'h5555;
        t1_before = t1;
        req_src = 3'd5; req_dst = 2'd1; req_valid = 1'b1;
        tick();                                   // into SEL
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_outs("abort_sel");
        chk("abort_sel_bus", 32'(BUS), 32'h0);
        tick();
        chk("abort_sel_ld2",   32'(LD),   32'h0);
        chk("abort_sel_done2", 32'(done), 32'h0);
        tick();
        chk("abort_sel_t1", 32'(t1), 32'(t1_before));

        // 6: three completed transfers, then one aborted in LOAD
        src_const = 16'h00C3;
        for (int k = 0; k < 3; k++) begin
            req_src = 3'd6; req_dst = 2'(k); req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            tick();
            chk($sformatf("cnt%0d_bus", k), 32'(BUS), 32'h00C3);
            tick();
        end
`ifdef BUS_TRANSFER_CTRL_XFER_CNT_EN
        chk("cnt_three", 32'(xfer_cnt), 32'h3);
`endif
        req_src = 3'd7; req_imm = 16'h7777; req_dst = 2'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();                                   // in LOAD
        chk("abort_load_ld", 32'(LD), 32'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_outs("abort_load");
        chk("abort_load_bus", 32'(BUS), 32'h0);
`ifdef BUS_TRANSFER_CTRL_XFER_CNT_EN
        chk("cnt_after_rst", 32'(xfer_cnt), 32'h0);
`endif
        tick();
        chk("abort_load_ld2", 32'(LD), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
